// File: rtl/product_bcd_display.sv
// product_bcd_display
//   Output stage of the sequential multiplier. When the multiplier raises
//   i_ready, the block captures the product magnitude and sign. It converts
//   the magnitude to BCD with a double-dabble that handles one bit per clock.
//   It then scans the result onto a multiplexed, active-low seven-segment
//   display: DIGITS decimal digits plus one sign slot.
//
//   Ports
//     i_clk / i_rst : clock (rising edge), async active-low reset
//     i_product     : unsigned product magnitude, DW bits
//     i_sign        : product sign, 1 = negative
//     i_ready       : multiplier result valid (level; rising edge starts)
//     o_bcd         : last completed BCD result, digit 0 in [3:0]
//     o_sign        : sign of last result, forced 0 for a zero magnitude
//     o_valid       : o_bcd/o_sign hold a completed conversion
//     o_busy        : conversion in progress
//     o_seg         : segments {g,f,e,d,c,b,a}, active-low
//     o_an          : one-hot anodes, active-low, bit DIGITS = sign slot

// Per-digit cell. It holds the double-dabble add-3 correction for one
// accumulator nibble and the segment decoder for one displayed nibble.
module pbd_digit (
  input  logic [3:0] i_acc_nib,
  input  logic [3:0] i_disp_nib,
  input  logic       i_blank,
  output logic [3:0] o_adj,
  output logic [6:0] o_seg
);
  always_comb begin
    o_adj = (i_acc_nib >= 4'd5) ? i_acc_nib + 4'd3 : i_acc_nib;
    o_seg = 7'h7F;
    if (!i_blank) begin
      case (i_disp_nib)
        4'd0:    o_seg = 7'h40;
        4'd1:    o_seg = 7'h79;
        4'd2:    o_seg = 7'h24;
        4'd3:    o_seg = 7'h30;
        4'd4:    o_seg = 7'h19;
        4'd5:    o_seg = 7'h12;
        4'd6:    o_seg = 7'h02;
        4'd7:    o_seg = 7'h78;
        4'd8:    o_seg = 7'h00;
        4'd9:    o_seg = 7'h10;
        default: o_seg = 7'h7F;
      endcase
    end
  end
endmodule

module product_bcd_display #(
  parameter int DW       = 16,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DW-1:0]         i_product,
  input  logic                  i_sign,
  input  logic                  i_ready,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_sign,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic [6:0]            o_seg,
  output logic [DIGITS:0]       o_an
);
  localparam int CW = $clog2(DW + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [BW-1:0] acc_q, acc_d;
  logic          sign_cap_q, sign_cap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          sign_q, sign_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic [SW-1:0] div_cnt_q, div_cnt_d;
  logic [IW-1:0] dig_idx_q, dig_idx_d;
  logic [DIGITS:0] an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [DIGITS-1:0][3:0] acc_adj;
  logic [DIGITS-1:0][6:0] dig_seg;
  logic [DIGITS:1]        lz;       // lz[k]: digit k and all above are zero
  logic [BW+DW-1:0]       cat_sh;
  logic                   start;

  assign lz[DIGITS] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      logic blank;
      if (g == 0) begin : g_lsd
        // The least significant digit always shows, so zero reads as '0'.
        assign blank = 1'b0;
      end else begin : g_hi
        assign lz[g] = lz[g+1] & ~|bcd_q[4*g +: 4];
        assign blank = lz[g];
      end
      pbd_digit u_dig (
        .i_acc_nib  (acc_q[4*g +: 4]),
        .i_disp_nib (bcd_q[4*g +: 4]),
        .i_blank    (blank),
        .o_adj      (acc_adj[g]),
        .o_seg      (dig_seg[g])
      );
    end
  endgenerate

  // Apply the add-3 correction first, then shift the {bcd, binary} pair by one bit.
  assign cat_sh = {acc_adj, shift_q} << 1;
  assign start  = i_ready & ~ready_q & (state_q == ST_IDLE);
  assign ready_d = i_ready;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    sign_cap_d = sign_cap_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d    = i_product;
          acc_d      = '0;
          sign_cap_d = i_sign;
          cnt_d      = CW'(DW);
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          state_d    = ST_CONV;
        end
      end
      default: begin
        acc_d   = cat_sh[BW+DW-1:DW];
        shift_d = cat_sh[DW-1:0];
        cnt_d   = cnt_q - 1'b1;
        // Publish only the finished value, so the display never sees partial sums.
        if (cnt_q == CW'(1)) begin
          bcd_d   = cat_sh[BW+DW-1:DW];
          sign_d  = sign_cap_q & |cat_sh[BW+DW-1:DW];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    dig_idx_d = dig_idx_q;
    if (div_cnt_q == SW'(SCAN_DIV - 1)) begin
      div_cnt_d = '0;
      dig_idx_d = (dig_idx_q == IW'(DIGITS)) ? '0 : dig_idx_q + 1'b1;
    end
  end

  // The anode and segment values are registered, so they follow dig_idx by one clock.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    if (valid_q) begin
      for (int k = 0; k <= DIGITS; k++) begin
        if (dig_idx_q == IW'(k)) an_d[k] = 1'b0;
      end
      if (dig_idx_q == IW'(DIGITS)) begin
        seg_d = sign_q ? 7'h3F : 7'h7F;
      end else begin
        for (int k = 0; k < DIGITS; k++) begin
          if (dig_idx_q == IW'(k)) seg_d = dig_seg[k];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      shift_q    <= '0;
      acc_q      <= '0;
      sign_cap_q <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      div_cnt_q  <= '0;
      dig_idx_q  <= '0;
      an_q       <= '1;
      seg_q      <= 7'h7F;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      sign_cap_q <= sign_cap_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      div_cnt_q  <= div_cnt_d;
      dig_idx_q  <= dig_idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign o_bcd   = bcd_q;
  assign o_sign  = sign_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_seg   = seg_q;
  assign o_an    = an_q;
endmodule
